// File: rtl/next_kms_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : next_kms_pkg                                                    |
// | Brief  : Shared types and LED pattern helpers for the NeXT               |
// |          keyboard/monitor bridge LED scheduler.                          |
// |          Contents: source enum, scheduler state enum, LED_RESET,         |
// |          pattern prefixes and pattern builder functions.                 |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
package next_kms_pkg;

  // Source currently owning the LEDs (value driven on the src port).
  typedef enum logic [1:0] {
    SRC_IDLE = 2'd0,
    SRC_KEY  = 2'd1,
    SRC_VOL  = 2'd2,
    SRC_MUTE = 2'd3
  } src_e;

  // Scheduler states share the source encoding so src is the state itself.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SHOW_KEY  = 2'd1,
    ST_SHOW_VOL  = 2'd2,
    ST_SHOW_MUTE = 2'd3
  } state_e;

  localparam logic [5:0] LED_RESET  = 6'b110011;

  localparam logic [0:0] c_pfx_key  = 1'b1;
  localparam logic [1:0] c_pfx_vol  = 2'b01;
  localparam logic [4:0] c_pfx_mute = 5'b00011;
  localparam logic [2:0] c_pfx_idle = 3'b000;

  function automatic logic [5:0] pat_key(input logic [4:0] code);
    return {c_pfx_key, code};
  endfunction

  function automatic logic [5:0] pat_vol(input logic [3:0] db);
    return {c_pfx_vol, db};
  endfunction

  function automatic logic [5:0] pat_mute(input logic muted);
    return {c_pfx_mute, muted};
  endfunction

  function automatic logic [5:0] pat_idle(input logic [2:0] dbg);
    return {c_pfx_idle, dbg};
  endfunction

endpackage
`default_nettype wire

// File: rtl/next_hold_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : next_hold_timer                                                 |
// | Brief  : Loadable down-counter with a zero flag.                         |
// |          Ports: clk, rst (async, active-high), load/load_val (load wins  |
// |          over dec), dec (decrement by one), zero (count == 0).           |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module next_hold_timer #(
  parameter int unsigned      CNT_W     = 32,
  parameter logic [CNT_W-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= RESET_VAL;
    end else if (load) begin
      r_count <= load_val;
    end else if (dec) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/next_led_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : next_led_scheduler                                              |
// | Brief  : Time-shares the six active-low board LEDs between keycode,      |
// |          volume, mute and debug-bit requesters. Each event is held for a |
// |          per-source time; events arriving meanwhile wait one-deep per    |
// |          source and are served KEY > VOL > MUTE.                         |
// | Ports  : clk, rst (async, active-high), key_valid/key_code,              |
// |          vol_valid/vol_db, is_muted (level, edges are events), debug,    |
// |          led_n (active-low LEDs), src (0 idle,1 key,2 vol,3 mute), busy. |
// | Config : NEXT_LEDSCHED_VOL_EN compiles in the VOL and MUTE sources;      |
// |          without it only the KEY and IDLE paths exist.                   |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module next_led_scheduler
  import next_kms_pkg::*;
#(
  parameter int unsigned HOLD_KEY  = 27000000,
  parameter int unsigned HOLD_VOL  = 13500000,
  parameter int unsigned HOLD_IDLE = 6750000,
  parameter int unsigned CNT_W     = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [15:0] key_code,
  input  logic        vol_valid,
  input  logic [11:0] vol_db,
  input  logic        is_muted,
  input  logic [2:0]  debug,
  output logic [5:0]  led_n,
  output logic [1:0]  src,
  output logic        busy
);

  localparam logic [CNT_W-1:0] c_reload_key  = CNT_W'(HOLD_KEY - 1);
  localparam logic [CNT_W-1:0] c_reload_vol  = CNT_W'(HOLD_VOL - 1);
  localparam logic [CNT_W-1:0] c_reload_idle = CNT_W'(HOLD_IDLE - 1);

  state_e           r_state, w_state_nx;
  logic [5:0]       r_led_buf, w_led_nx;
  logic             w_tmr_load, w_tmr_dec, w_tmr_zero;
  logic [CNT_W-1:0] w_tmr_val;
  logic             w_any_pend;

  // ---------------------------------------------------------------- KEY pending
  logic       r_kp;
  logic [4:0] r_key_data;
  logic       w_clr_key;

  // A new pulse in the same cycle as the clear keeps the flag set with new data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_kp       <= 1'b0;
      r_key_data <= '0;
    end else if (key_valid) begin
      r_kp       <= 1'b1;
      r_key_data <= key_code[4:0];
    end else if (w_clr_key) begin
      r_kp       <= 1'b0;
    end
  end

  logic w_unused_key;
  assign w_unused_key = ^key_code[15:5];

`ifdef NEXT_LEDSCHED_VOL_EN
  // ------------------------------------------------------- VOL / MUTE pending
  logic       r_vp, r_mp;
  logic [3:0] r_vol_data;
  logic       r_mute_data;
  logic       r_mute_prev, r_mute_armed;
  logic       w_clr_vol, w_clr_mute, w_mute_evt;

  // The armed bit suppresses a spurious MUTE event on the first clock out of
  // reset, when r_mute_prev has not yet seen the real is_muted level.
  assign w_mute_evt = r_mute_armed && (is_muted != r_mute_prev);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vp         <= 1'b0;
      r_vol_data   <= '0;
      r_mp         <= 1'b0;
      r_mute_data  <= 1'b0;
      r_mute_prev  <= 1'b0;
      r_mute_armed <= 1'b0;
    end else begin
      r_mute_prev  <= is_muted;
      r_mute_armed <= 1'b1;
      if (vol_valid) begin
        r_vp       <= 1'b1;
        r_vol_data <= vol_db[3:0];
      end else if (w_clr_vol) begin
        r_vp       <= 1'b0;
      end
      if (w_mute_evt) begin
        r_mp        <= 1'b1;
        r_mute_data <= is_muted;
      end else if (w_clr_mute) begin
        r_mp        <= 1'b0;
      end
    end
  end

  assign w_any_pend = r_kp | r_vp | r_mp;

  logic w_unused_ins;
  assign w_unused_ins = ^vol_db[11:4];
`else
  assign w_any_pend = r_kp;

  logic w_unused_ins;
  assign w_unused_ins = ^{vol_valid, vol_db, is_muted, c_reload_vol};
`endif

  // ---------------------------------------------------------------- hold timer
  next_hold_timer #(
    .CNT_W     (CNT_W),
    .RESET_VAL (c_reload_idle)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (w_tmr_load),
    .load_val (w_tmr_val),
    .dec      (w_tmr_dec),
    .zero     (w_tmr_zero)
  );

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_led_buf <= LED_RESET;
    end else begin
      r_state   <= w_state_nx;
      r_led_buf <= w_led_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_led_nx   = r_led_buf;
    w_tmr_load = 1'b0;
    w_tmr_val  = c_reload_idle;
    w_tmr_dec  = 1'b0;
    w_clr_key  = 1'b0;
`ifdef NEXT_LEDSCHED_VOL_EN
    w_clr_vol  = 1'b0;
    w_clr_mute = 1'b0;
`endif
    // IDLE hands over as soon as anything is pending; a SHOW state only hands
    // over when its hold counter has run out.
    if ((r_state == ST_IDLE) ? !w_any_pend : !w_tmr_zero) begin
      if ((r_state == ST_IDLE) && w_tmr_zero) begin
        w_led_nx   = pat_idle(debug);
        w_tmr_load = 1'b1;
        w_tmr_val  = c_reload_idle;
      end else begin
        w_tmr_dec  = 1'b1;
      end
    end else if (r_kp) begin
      w_state_nx = ST_SHOW_KEY;
      w_led_nx   = pat_key(r_key_data);
      w_tmr_load = 1'b1;
      w_tmr_val  = c_reload_key;
      w_clr_key  = 1'b1;
    end
`ifdef NEXT_LEDSCHED_VOL_EN
    else if (r_vp) begin
      w_state_nx = ST_SHOW_VOL;
      w_led_nx   = pat_vol(r_vol_data);
      w_tmr_load = 1'b1;
      w_tmr_val  = c_reload_vol;
      w_clr_vol  = 1'b1;
    end else if (r_mp) begin
      w_state_nx = ST_SHOW_MUTE;
      w_led_nx   = pat_mute(r_mute_data);
      w_tmr_load = 1'b1;
      w_tmr_val  = c_reload_vol;
      w_clr_mute = 1'b1;
    end
`endif
    else begin
      // Hold finished with nothing waiting: show debug bits right away.
      w_state_nx = ST_IDLE;
      w_led_nx   = pat_idle(debug);
      w_tmr_load = 1'b1;
      w_tmr_val  = c_reload_idle;
    end
  end

  assign led_n = ~r_led_buf;
  assign src   = r_state;
  assign busy  = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: doc/next_led_scheduler.md
# next_led_scheduler

Time-shares the six board LEDs of the NeXT keyboard/monitor bridge between status requesters: keyboard keycodes, volume changes, mute changes and the sound-box debug bits. Sits in the top level between the sound-box core's status outputs and the active-low `led` pins. Each event is shown for a per-source hold time. Events that arrive while another is being shown are queued one-deep per source and served in fixed priority order.

## Interface
Parameters:
- `HOLD_KEY`, 27000000: keycode display time in clk cycles (1 s at 27 MHz).
- `HOLD_VOL`, 13500000: volume and mute display time in cycles.
- `HOLD_IDLE`, 6750000: debug-bit resample period in cycles.
- `CNT_W`, 32: hold counter width. Every `HOLD_*` is ≥1 and fits in `CNT_W`.

Ports:
- `clk`, in, 1: 27 MHz system clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `key_valid`, in, 1: one-cycle pulse; `key_code` is valid in that cycle.
- `key_code`, in, 16: NeXT keycode.
- `vol_valid`, in, 1: one-cycle pulse; `vol_db` is valid in that cycle.
- `vol_db`, in, 12: attenuation in dB.
- `is_muted`, in, 1: level signal; every change of level is an event.
- `debug`, in, 3: free-running debug bits.
- `led_n`, out, 6: LED drive, active-low. Equals ~`led_buf`.
- `src`, out, 2: source currently shown. 0 = IDLE, 1 = KEY, 2 = VOL, 3 = MUTE.
- `busy`, out, 1: high while a KEY, VOL or MUTE hold is running.

## Operation
- Reset values:
  - `led_buf` = 6'b110011, so `led_n` = 6'b001100.
  - `src` = 0, `busy` = 0.
  - Counter = `HOLD_IDLE`-1.
  - All pending flags clear.
  - The previous-`is_muted` register loads the current `is_muted` on the first clock after reset, so leaving reset never creates a MUTE event.
- Pending capture, every cycle:
  - `key_valid` sets `kp` and stores `key_code[4:0]`.
  - `vol_valid` sets `vp` and stores `vol_db[3:0]`.
  - A change in `is_muted` sets `mp` and stores the new level.
  - A newer event overwrites an older pending value of the same source.
  - If a set and a clear of the same flag happen in the same cycle, the set wins and the new data is kept.
- FSM states: IDLE, SHOW_KEY, SHOW_VOL, SHOW_MUTE.
  - IDLE: any pending flag makes the FSM leave IDLE on the next edge, preempting the idle period.
  - Selection priority: KEY > VOL > MUTE.
  - When a source is selected, its flag is cleared, its pattern is loaded and the counter is loaded with `HOLD_x`-1.
  - IDLE with nothing pending and counter = 0: load `{3'b000, debug}` and reload `HOLD_IDLE`-1.
  - SHOW_x states are never preempted. The counter decrements each cycle. At 0 the FSM selects the highest pending source, or enters IDLE if nothing is pending.
  - Entering IDLE loads the debug pattern immediately.
- LED patterns (`led_buf`):
  - KEY: `{1'b1, code[4:0]}`.
  - VOL: `{2'b01, db[3:0]}`.
  - MUTE: `{5'b00011, muted}`.
  - IDLE: `{3'b000, debug}`.
- Counter arithmetic is unsigned `CNT_W`-bit. The counter never underflows because it is always reloaded at 0.

## Timing
- Event pulse in cycle N: the pending flag is set at the end of N.
- From IDLE: `led_n`, `src` and `busy` change at the edge ending N+1, so the event is visible one cycle after the pulse.
- A SHOW_x pattern stays on `led_n` for exactly `HOLD_x` cycles. The next pattern appears on the following edge, with no gap cycle.
- Back-to-back KEY pulses during SHOW_KEY: only the last one is shown after the current hold ends.
- `rst` asserted mid-hold: all outputs return to their reset values asynchronously and all pending events are discarded.

## Configuration
- `NEXT_LEDSCHED_VOL_EN` defined: VOL and MUTE sources, their pending logic and their states are compiled in.
- Not defined: `vol_valid`, `vol_db` and `is_muted` are ignored; `src` only takes the values 0 and 1; only the KEY and IDLE paths exist.

## Structure
- Shared package `next_kms_pkg`:
  - 2-bit source enum (IDLE/KEY/VOL/MUTE).
  - `LED_RESET` = 6'b110011.
  - Pattern prefix constants.
- One sub-module, `next_hold_timer`: a loadable down-counter with a `zero` flag, `CNT_W` wide.
- The FSM and pending registers live in the top module.

## Test plan
All scenarios use `HOLD_KEY`=8, `HOLD_VOL`=4, `HOLD_IDLE`=2.
1. Reset, then `debug`=3'b101 held constant: `led_n` = 6'b001100 until the first idle reload, then ~6'b000101 = 6'b111010, resampled every 2 cycles.
2. `key_valid` pulse with `key_code`=16'h0015: `led_n` = ~6'b110101 = 6'b001010 from N+1 for 8 cycles, `src`=1, `busy`=1; then idle pattern, `busy`=0.
3. `key_valid` (code 5'h03) and `vol_valid` (db=4'h9) in the same cycle: KEY shown for 8 cycles, then VOL `{01,1001}` for 4 cycles, then IDLE.
4. `is_muted` rises during SHOW_KEY, then `key_valid` (code 5'h07) arrives before the hold ends: after the current hold, the new KEY is shown, then MUTE `{00011,1}`.
5. `rst` pulsed in cycle 3 of SHOW_VOL with KEY pending: `led_n` = 6'b001100 and `src`=0 immediately; the pending KEY is never displayed.
6. Build without `NEXT_LEDSCHED_VOL_EN`: `vol_valid` and `is_muted` toggles leave `src`=0 and the idle pattern unchanged.
